// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: scrolls a DIGITS-wide window over a fixed hex message on a multiplexed
// common-anode 7-segment display, stepped by a debounced button or a periodic auto-step.
module seg_msg_scroller #(
    parameter int          DIGITS          = 4,
    parameter int          MSG_LEN         = 16,
    parameter logic [63:0] MESSAGE         = 64'h0123456789ABCDEF,
    parameter int          REFRESH_DIV     = 50000,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          AUTO_PERIOD     = 50000000,
    localparam int         PTR_W           = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button_move,
    input  logic              dir,
    input  logic              auto_en,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [PTR_W-1:0]  pointer
);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int AW = $clog2(AUTO_PERIOD);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PTR_W:0] LEN = (PTR_W+1)'(MSG_LEN);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic [3:0] chars [MSG_LEN];
    for (genvar g = 0; g < MSG_LEN; g++) begin : g_chars
        assign chars[g] = MESSAGE[4*(MSG_LEN-1-g) +: 4];
    end

    logic          sync1, sync2, sync3, db_level, db_level_q;
    logic [BW-1:0] db_cnt;
    logic [AW-1:0] auto_cnt;
    logic [RW-1:0] ref_cnt;
    logic [DW-1:0] digit;
    logic          btn_step, auto_step, step;
    logic [PTR_W:0]   step_sum, char_sum;
    logic [PTR_W-1:0] ptr_nxt, char_idx;
    logic [3:0]       msg_char;

    always_comb begin
        btn_step  = db_level & ~db_level_q;
        auto_step = auto_en && auto_cnt == AW'(AUTO_PERIOD - 1);
        step      = btn_step | auto_step;
        step_sum  = {1'b0, pointer} + (dir ? LEN - 1'b1 : (PTR_W+1)'(1));
        ptr_nxt   = step_sum >= LEN ? PTR_W'(step_sum - LEN) : PTR_W'(step_sum);
        // leftmost digit (highest index) shows pointer, so offset is DIGITS-1-digit
        char_sum  = {1'b0, pointer} + (PTR_W+1)'(DIGITS - 1) - (PTR_W+1)'(digit);
        char_idx  = char_sum >= LEN ? PTR_W'(char_sum - LEN) : PTR_W'(char_sum);
        msg_char  = chars[char_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_q <= 1'b0;
            auto_cnt   <= '0;
            ref_cnt    <= '0;
            digit      <= '0;
            pointer    <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            sync1      <= button_move;
            sync2      <= sync1;
            sync3      <= sync2;
            db_cnt     <= (sync2 != sync3) ? '0 : (db_cnt == BW'(DEBOUNCE_CYCLES)) ? db_cnt : db_cnt + 1'b1;
            db_level   <= (db_cnt == BW'(DEBOUNCE_CYCLES)) ? sync3 : db_level;
            db_level_q <= db_level;
            auto_cnt   <= (!auto_en || auto_step) ? '0 : auto_cnt + 1'b1;
            ref_cnt    <= (ref_cnt == RW'(REFRESH_DIV - 1)) ? '0 : ref_cnt + 1'b1;
            if (ref_cnt == RW'(REFRESH_DIV - 1))
                digit <= (digit == DW'(DIGITS - 1)) ? '0 : digit + 1'b1;
            if (step)
                pointer <= ptr_nxt;
            an  <= ~(DIGITS'(1) << digit);
            seg <= SEG_LUT[msg_char];
            dp  <= char_idx != '0;
        end
    end
endmodule

// File: tb/tb_seg_msg_scroller.sv
// tb_seg_msg_scroller: directed checks of scan, debounce, auto-step, direction wrap and reset abort.
module tb_seg_msg_scroller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button_move = 1'b0;
    logic       dir = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] pointer;
    int n_cmp = 0;
    int n_bad = 0;

    seg_msg_scroller #(
        .DIGITS(4), .MSG_LEN(16), .MESSAGE(64'h0123456789ABCDEF),
        .REFRESH_DIV(4), .DEBOUNCE_CYCLES(8), .AUTO_PERIOD(64)
    ) dut (
        .clk(clk), .reset(reset), .button_move(button_move), .dir(dir), .auto_en(auto_en),
        .an(an), .seg(seg), .dp(dp), .pointer(pointer)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL rst_an: got %b want 1111", an); end
        n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL rst_seg: got %h want 7F", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL rst_dp: got %b want 1", dp); end
        n_cmp++; if (pointer !== 4'd0) begin n_bad++; $display("FAIL rst_ptr: got %0d want 0", pointer); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (an !== 4'b1110 || seg !== 7'h06 || dp !== 1'b1) begin n_bad++; $display("FAIL scan_d0: got an=%b seg=%h dp=%b want 1110/06/1", an, seg, dp); end
        repeat (4) @(negedge clk);
        n_cmp++; if (an !== 4'b1101 || seg !== 7'h12) begin n_bad++; $display("FAIL scan_d1: got an=%b seg=%h want 1101/12", an, seg); end
        repeat (4) @(negedge clk);
        n_cmp++; if (an !== 4'b1011 || seg !== 7'h4F) begin n_bad++; $display("FAIL scan_d2: got an=%b seg=%h want 1011/4F", an, seg); end
        repeat (4) @(negedge clk);
        n_cmp++; if (an !== 4'b0111 || seg !== 7'h01 || dp !== 1'b0) begin n_bad++; $display("FAIL scan_d3: got an=%b seg=%h dp=%b want 0111/01/0", an, seg, dp); end
    endtask

    task automatic test_debounce();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            button_move = ~button_move;
            repeat (3) @(negedge clk);
        end
        n_cmp++; if (pointer !== 4'd0) begin n_bad++; $display("FAIL bounce_ptr: got %0d want 0", pointer); end
        button_move = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (pointer !== 4'd1) begin n_bad++; $display("FAIL hold_ptr: got %0d want 1", pointer); end
        button_move = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++; if (pointer !== 4'd1) begin n_bad++; $display("FAIL release_ptr: got %0d want 1", pointer); end
    endtask

    task automatic test_dir_wrap();
        int t;
        do_reset();
        dir = 1'b1;
        button_move = 1'b1;
        repeat (20) @(negedge clk);
        button_move = 1'b0;
        repeat (20) @(negedge clk);
        dir = 1'b0;
        n_cmp++; if (pointer !== 4'd15) begin n_bad++; $display("FAIL dir_ptr: got %0d want 15", pointer); end
        t = 0;
        while (an !== 4'b0111 && t < 20) begin @(negedge clk); t++; end
        n_cmp++; if (an !== 4'b0111 || seg !== 7'h38 || dp !== 1'b1) begin n_bad++; $display("FAIL dir_left: got an=%b seg=%h dp=%b want 0111/38/1", an, seg, dp); end
        t = 0;
        while (an !== 4'b1011 && t < 20) begin @(negedge clk); t++; end
        n_cmp++; if (an !== 4'b1011 || seg !== 7'h01 || dp !== 1'b0) begin n_bad++; $display("FAIL dir_zero: got an=%b seg=%h dp=%b want 1011/01/0", an, seg, dp); end
    endtask

    task automatic test_auto();
        do_reset();
        auto_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            repeat (63) @(negedge clk);
            n_cmp++; if (pointer !== 4'(k - 1)) begin n_bad++; $display("FAIL auto_pre%0d: got %0d want %0d", k, pointer, k - 1); end
            @(negedge clk);
            n_cmp++; if (pointer !== 4'(k % 16)) begin n_bad++; $display("FAIL auto_step%0d: got %0d want %0d", k, pointer, k % 16); end
        end
        auto_en = 1'b0;
        repeat (200) @(negedge clk);
        n_cmp++; if (pointer !== 4'd0) begin n_bad++; $display("FAIL auto_off: got %0d want 0", pointer); end
    endtask

    task automatic test_coincident();
        do_reset();
        auto_en = 1'b1;
        repeat (51) @(negedge clk);
        button_move = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if (pointer !== 4'd0) begin n_bad++; $display("FAIL coin_pre: got %0d want 0", pointer); end
        @(negedge clk);
        n_cmp++; if (pointer !== 4'd1) begin n_bad++; $display("FAIL coin_step: got %0d want 1", pointer); end
        repeat (16) @(negedge clk);
        button_move = 1'b0;
        auto_en = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (pointer !== 4'd1) begin n_bad++; $display("FAIL coin_post: got %0d want 1", pointer); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_en = 1'b1;
        repeat (320) @(negedge clk);
        n_cmp++; if (pointer !== 4'd5) begin n_bad++; $display("FAIL mid_pre: got %0d want 5", pointer); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (pointer !== 4'd0 || an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin n_bad++; $display("FAIL mid_rst: got ptr=%0d an=%b seg=%h dp=%b want 0/1111/7F/1", pointer, an, seg, dp); end
        @(negedge clk);
        reset = 1'b0;
        repeat (63) @(negedge clk);
        n_cmp++; if (pointer !== 4'd0) begin n_bad++; $display("FAIL mid_nopend: got %0d want 0", pointer); end
        @(negedge clk);
        n_cmp++; if (pointer !== 4'd1) begin n_bad++; $display("FAIL mid_resume: got %0d want 1", pointer); end
        auto_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_dir_wrap();
        test_auto();
        test_coincident();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
